riscv_div_seq: RTL

//  Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions; the

---
 rtl/riscv_m_pkg.sv | 27 ++
 rtl/riscv_div_step.sv | 28 ++
 rtl/riscv_div_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/riscv_m_pkg.sv
// Shared types and constants for the RV32M unit (multiplier and sequential divider).
package riscv_m_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

  localparam int          DIV_ITERS  = 32;
  localparam logic [31:0] DIV_Q_ZERO = 32'hFFFF_FFFF;

endpackage

// File: rtl/riscv_div_step.sv
// One restoring-division step: shift {r,q} left, subtract d when it fits.
module riscv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] r_nxt,
  output logic [XLEN-1:0] q_nxt
);

  logic [XLEN:0] r_sh;
  logic [XLEN:0] diff;

  // r < d always holds, so a borrow shows up as the top bit of the 33-bit difference
  always_comb begin
    r_sh = {r, q[XLEN-1]};
    diff = r_sh - {1'b0, d};
    if (!diff[XLEN]) begin
      r_nxt = diff[XLEN-1:0];
      q_nxt = {q[XLEN-2:0], 1'b1};
    end else begin
      r_nxt = r_sh[XLEN-1:0];
      q_nxt = {q[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/riscv_div_seq.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero, overflow and |rs1|<|rs2| finish in one cycle.
module riscv_div_seq
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [1:0]      div_op,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd
);

  if (XLEN != 32) begin : g_xlen_check
    $error("riscv_div_seq supports XLEN=32 only");
  end

  localparam logic [4:0] LAST_CNT = 5'(DIV_ITERS - 1);

  div_state_t      state, state_nxt;
  logic [XLEN-1:0] rem, quo, dvs;
  logic [XLEN-1:0] step_r, step_q;
  logic [4:0]      cnt;
  div_op_t         op_r;
  logic            neg_q, neg_r;
  logic            accept, early, in_signed;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] quo_fix, rem_fix, final_rd;
`ifdef DIV_EARLY_OUT_EN
  logic [XLEN-1:0] early_rd;
`endif

  riscv_div_step #(.XLEN(XLEN)) u_step (
    .r     (rem),
    .q     (quo),
    .d     (dvs),
    .r_nxt (step_r),
    .q_nxt (step_q)
  );

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    accept    = in_valid & in_ready & ~kill;
    in_signed = ~div_op[0];
    a_abs     = (in_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    b_abs     = (in_signed && rs2[XLEN-1]) ? -rs2 : rs2;
    early     = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    early_rd  = div_op[1] ? rs1 : '0;
    if (rs2 == '0) begin
      early    = 1'b1;
      early_rd = div_op[1] ? rs1 : DIV_Q_ZERO;
    end else if (in_signed && rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF) begin
      early    = 1'b1;
      early_rd = div_op[1] ? '0 : 32'h8000_0000;
    end else if (a_abs < b_abs) begin
      early    = 1'b1;
    end
`endif
  end

  // Zero divisor leaves q all ones and r=|rs1|; only the quotient needs overriding.
  always_comb begin
    quo_fix  = (!op_r[0] && neg_q) ? -step_q : step_q;
    if (dvs == '0) quo_fix = DIV_Q_ZERO;
    rem_fix  = (!op_r[0] && neg_r) ? -step_r : step_r;
    final_rd = op_r[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = early ? DONE : BUSY;
      BUSY: if (cnt == LAST_CNT) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      op_r  <= DIV;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rd    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rem   <= '0;
        quo   <= a_abs;
        dvs   <= b_abs;
        cnt   <= '0;
        op_r  <= div_op_t'(div_op);
        neg_q <= rs1[XLEN-1] ^ rs2[XLEN-1];
        neg_r <= rs1[XLEN-1];
`ifdef DIV_EARLY_OUT_EN
        if (early) rd <= early_rd;
`endif
      end else if (state == BUSY && !kill) begin
        rem <= step_r;
        quo <= step_q;
        cnt <= cnt + 5'd1;
        if (cnt == LAST_CNT) rd <= final_rd;
      end
    end
  end

endmodule
